imm_extend_pipe: RTL
====================

// Module: imm_extend_pipe
// PURPOSE
//  Parametrised, pipelined successor to the combinational immediate sign-extender.
//  Extracts the immediate of an I/D/B/CB/IW instruction from the low 26 instruction bits.
//  Zero- or sign-extends it to DATA_W, applies the IW halfword shift and flags illegal encodings.
//  Sits between the decode and execute stages; a valid/ready handshake on both sides carries stalls.
// PARAMETERS
//  DATA_W   64  output width; multiple of 16, >= 32
//  HW_LANES DATA_W/16  derived number of IW halfword positions (localparam, not overridable)
// PORTS
//  CLK        in   1       clock, rising edge
//  Reset      in   1       synchronous, active-high
//  flush      in   1       drop all in-flight entries (branch redirect)
//  in_valid   in   1       Imm26/Ctrl are valid
//  in_ready   out  1       block accepts this cycle
//  Imm26      in   26      instruction bits [25:0]
//  Ctrl       in   3       format select (see BEHAVIOUR)
//  out_valid  out  1       BusImm/err are valid
//  out_ready  in   1       consumer accepts this cycle
//  BusImm     out  DATA_W  extended immediate
//  err        out  1       illegal Ctrl or IW shift beyond DATA_W
// BEHAVIOUR
//  Format select (Ctrl):
//    0 I:  zext(Imm26[21:10])
//    1 D:  sext(Imm26[20:12])
//    2 B:  sext(Imm26[25:0])
//    3 CB: sext(Imm26[23:5])
//    4 IW: zext(Imm26[20:5]) << 16*Imm26[22:21]
//    5 IWK: see CONFIGURATION
//    6,7: BusImm=0, err=1
//  IW shift: if Imm26[22:21] >= HW_LANES, then BusImm=0 and err=1 (e.g. hw=2 or 3 when DATA_W=32).
//  Pipeline: two register stages, S1 (field extract + extension kind) and S2 (shift/merge -> output).
//  Latency: 2 cycles from in_valid&&in_ready to out_valid. Throughput: 1 per cycle with no stall.
//  Handshake: a transfer occurs on valid&&ready.
//    - Once asserted, out_valid stays high and BusImm/err stay stable until out_ready.
//    - in_ready = !S1.v || (!S2.v || out_ready). It is combinational from out_ready; no skid buffer.
//    - Stage advance: S2 loads S1 when S2 is empty or draining. S1 loads input when S1 is empty or advancing.
//  Flush: both valid bits clear on the next edge, and the input sampled that cycle is discarded.
//    flush takes priority over in_valid and over out_ready.
//  Reset: S1.v=S2.v=0, out_valid=0, BusImm=0, err=0.
//    in_ready is 1 on the first cycle after Reset deasserts.
//    Reset asserted mid-stream drops all entries with no partial output.
//  Data registers update only on load. Output data is don't-care while out_valid=0, but stays
//    at its held value; a bench may check that it is stable.
// CONFIGURATION
//  Macro IMM_MOVK_EN:
//    - Defined: adds port old_val (in, DATA_W), sampled with Imm26.
//      Ctrl=5 (IWK) gives old_val with halfword lane Imm26[22:21] replaced by Imm26[20:5].
//      An out-of-range lane gives BusImm=old_val, err=1.
//    - Undefined: old_val port is absent and Ctrl=5 is treated as illegal (BusImm=0, err=1).
// STRUCTURE
//  Package imm_ext_pkg:
//    - localparams CTRL_I=0, CTRL_D=1, CTRL_B=2, CTRL_CB=3, CTRL_IW=4, CTRL_IWK=5
//    - field msb/lsb constants per format
//    - S1 payload struct {kind, sign, raw[25:0], hw[1:0], bad}
//  Sub-module imm_field_extract: combinational S1 logic (Ctrl+Imm26 -> payload).
//    Reusable by the single-cycle datapath.
//  Top: S1/S2 registers, handshake, S2 shift/merge, flush/reset.
// TESTING
//  1. Ctrl=1, Imm26[20:12]=9'h1F0, DATA_W=64, steady ready
//     -> 2 cycles later BusImm=64'hFFFF_FFFF_FFFF_FFF0, err=0.
//  2. Ctrl=4, Imm26[20:5]=16'hBEEF, hw=3
//     -> BusImm=64'hBEEF_0000_0000_0000. With DATA_W=32 same input -> BusImm=0, err=1.
//  3. Back-to-back stream of 8 I/B/CB ops, out_ready low cycles 3-5
//     -> in_ready falls, no op lost/duplicated, BusImm held stable while stalled,
//        order preserved against the reference model.
//  4. flush with both stages full and in_valid=1 -> out_valid=0 next cycle, the next accepted op emerges
//     2 cycles after its acceptance.
//  5. Reset asserted for 1 cycle mid-stream -> out_valid=0, BusImm=0, err=0, in_ready=1 after release.
//  6. Under IMM_MOVK_EN: old_val=64'h1111_2222_3333_4444, Ctrl=5, hw=1, imm=16'hABCD
//     -> BusImm=64'h1111_2222_ABCD_4444. Without the macro, Ctrl=5 -> err=1.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the pipelined immediate extender: format codes,
// instruction field positions and the payload carried from S1 to S2.
package imm_ext_pkg;

    // Ctrl format codes
    localparam logic [2:0] CTRL_I   = 3'd0;
    localparam logic [2:0] CTRL_D   = 3'd1;
    localparam logic [2:0] CTRL_B   = 3'd2;
    localparam logic [2:0] CTRL_CB  = 3'd3;
    localparam logic [2:0] CTRL_IW  = 3'd4;
    localparam logic [2:0] CTRL_IWK = 3'd5;

    // Field positions inside Imm26
    localparam int I_MSB  = 21;
    localparam int I_LSB  = 10;
    localparam int D_MSB  = 20;
    localparam int D_LSB  = 12;
    localparam int CB_MSB = 23;
    localparam int CB_LSB = 5;
    localparam int IW_MSB = 20;
    localparam int IW_LSB = 5;
    localparam int HW_MSB = 22;
    localparam int HW_LSB = 21;

    // What S2 has to do with the payload
    typedef enum logic [1:0] {
        KIND_EXT = 2'd0,  // raw already extended to 26 bits; widen with sign
        KIND_IW  = 2'd1,  // place raw[15:0] in halfword lane hw
        KIND_IWK = 2'd2,  // replace lane hw of the old value with raw[15:0]
        KIND_ILL = 2'd3   // illegal format, result is zero
    } kind_e;

    typedef struct packed {
        kind_e       kind;
        logic        sign;  // replicate raw[25] above bit 25
        logic [25:0] raw;
        logic [1:0]  hw;
        logic        bad;   // illegal Ctrl or lane outside DATA_W
    } s1_payload_t;

endpackage

// File: rtl/imm_field_extract.sv
// Combinational S1 logic: picks the immediate field for the selected format,
// pre-extends signed fields to 26 bits and flags illegal encodings.
// Optional IWK format is enabled by macro IMM_MOVK_EN.
module imm_field_extract
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [2:0]  ctrl,
    input  logic [25:0] imm26,
    output s1_payload_t payload
);

    localparam int HW_LANES = DATA_W / 16;

    logic lane_oob;

    // Field selection and classification per format
    always_comb begin
        payload      = '0;
        payload.kind = KIND_EXT;
        payload.hw   = imm26[HW_MSB:HW_LSB];
        lane_oob     = (int'(imm26[HW_MSB:HW_LSB]) >= HW_LANES);
        case (ctrl)
            CTRL_I: begin
                payload.raw = 26'(imm26[I_MSB:I_LSB]);
            end
            CTRL_D: begin
                payload.raw  = {{17{imm26[D_MSB]}}, imm26[D_MSB:D_LSB]};
                payload.sign = 1'b1;
            end
            CTRL_B: begin
                payload.raw  = imm26;
                payload.sign = 1'b1;
            end
            CTRL_CB: begin
                payload.raw  = {{7{imm26[CB_MSB]}}, imm26[CB_MSB:CB_LSB]};
                payload.sign = 1'b1;
            end
            CTRL_IW: begin
                payload.kind = KIND_IW;
                payload.raw  = 26'(imm26[IW_MSB:IW_LSB]);
                payload.bad  = lane_oob;
            end
`ifdef IMM_MOVK_EN
            CTRL_IWK: begin
                payload.kind = KIND_IWK;
                payload.raw  = 26'(imm26[IW_MSB:IW_LSB]);
                payload.bad  = lane_oob;
            end
`endif
            default: begin
                payload.kind = KIND_ILL;
                payload.bad  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage pipelined immediate extender. S1 registers the extracted field,
// S2 registers the shifted/merged result that drives BusImm/err.
// Macro IMM_MOVK_EN adds the old_val port and the IWK (keep/insert) format.
//
// Handshake: a beat moves on valid && ready. out_valid, once high, holds with
// BusImm/err stable until out_ready. in_ready = !S1.v || !S2.v || out_ready,
// combinational from out_ready (no skid buffer). flush beats everything:
// both stages empty on the next edge and the input of that cycle is dropped.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [25:0]       Imm26,
    input  logic [2:0]        Ctrl,
`ifdef IMM_MOVK_EN
    input  logic [DATA_W-1:0] old_val,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] BusImm,
    output logic              err
);

    s1_payload_t       ext_pl;
    logic              s1_v_q, s1_v_d;
    s1_payload_t       s1_pl_q, s1_pl_d;
    logic              s2_v_q, s2_v_d;
    logic [DATA_W-1:0] s2_imm_q, s2_imm_d;
    logic              s2_err_q, s2_err_d;
`ifdef IMM_MOVK_EN
    logic [DATA_W-1:0] s1_old_q, s1_old_d;
`endif

    logic              s1_load, s2_load;
    logic [5:0]        shamt;
    logic [DATA_W-1:0] lane_word, lane_mask, merge_imm;
    logic              merge_err;

    imm_field_extract #(.DATA_W(DATA_W)) u_extract (
        .ctrl    (Ctrl),
        .imm26   (Imm26),
        .payload (ext_pl)
    );

    // S2 datapath: widen, or position the halfword in its lane
    always_comb begin
        shamt     = {s1_pl_q.hw, 4'b0000};
        lane_word = '0;
        lane_word[15:0] = s1_pl_q.raw[15:0];
        lane_word = lane_word << shamt;
        lane_mask = '0;
        lane_mask[15:0] = 16'hFFFF;
        lane_mask = lane_mask << shamt;
        merge_imm = '0;
        merge_err = s1_pl_q.bad;
        case (s1_pl_q.kind)
            KIND_EXT: merge_imm = {{(DATA_W-26){s1_pl_q.sign & s1_pl_q.raw[25]}}, s1_pl_q.raw};
            KIND_IW:  merge_imm = s1_pl_q.bad ? '0 : lane_word;
`ifdef IMM_MOVK_EN
            KIND_IWK: merge_imm = s1_pl_q.bad ? s1_old_q
                                              : ((s1_old_q & ~lane_mask) | lane_word);
`endif
            default:  merge_imm = '0;
        endcase
    end

    // Handshake, stage advance and flush; data registers change only on load
    always_comb begin
        in_ready = !s1_v_q || !s2_v_q || out_ready;
        s2_load  = s1_v_q && (!s2_v_q || out_ready);
        s1_load  = in_valid && in_ready;
        s1_v_d   = s1_v_q;
        s1_pl_d  = s1_pl_q;
        s2_v_d   = s2_v_q;
        s2_imm_d = s2_imm_q;
        s2_err_d = s2_err_q;
`ifdef IMM_MOVK_EN
        s1_old_d = s1_old_q;
`endif
        if (flush) begin
            s1_v_d = 1'b0;
            s2_v_d = 1'b0;
        end else begin
            if (s2_load) begin
                s2_v_d   = 1'b1;
                s2_imm_d = merge_imm;
                s2_err_d = merge_err;
            end else if (out_ready) begin
                s2_v_d = 1'b0;
            end
            if (s1_load) begin
                s1_v_d  = 1'b1;
                s1_pl_d = ext_pl;
`ifdef IMM_MOVK_EN
                s1_old_d = old_val;
`endif
            end else if (s2_load) begin
                s1_v_d = 1'b0;
            end
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (Reset) begin
            s1_v_q   <= 1'b0;
            s1_pl_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_imm_q <= '0;
            s2_err_q <= 1'b0;
`ifdef IMM_MOVK_EN
            s1_old_q <= '0;
`endif
        end else begin
            s1_v_q   <= s1_v_d;
            s1_pl_q  <= s1_pl_d;
            s2_v_q   <= s2_v_d;
            s2_imm_q <= s2_imm_d;
            s2_err_q <= s2_err_d;
`ifdef IMM_MOVK_EN
            s1_old_q <= s1_old_d;
`endif
        end
    end

    assign out_valid = s2_v_q;
    assign BusImm    = s2_imm_q;
    assign err       = s2_err_q;

endmodule
